// File: rtl/bcd_display_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD display counter.
// Digit range limit, blank segment pattern and load clamping.
package bcd_display_counter_pkg;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > DIGIT_MAX) ? DIGIT_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD to active-low seven-segment decoder.
// Bit k drives segment k (a..g); non-BCD codes go dark.
module bcd7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter: next-value and carry/borrow logic.
// Cells chain through en/co so a carry ripples in one cycle.
module bcd_digit_cell
  import bcd_display_counter_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_nib,
  output logic [3:0] nxt,
  output logic       co
);

  always_comb begin
    nxt = digit;
    co  = 1'b0;
    if (load) begin
      nxt = bcd_clamp(load_nib);
    end else if (en && up) begin
      if (digit >= DIGIT_MAX) begin
        nxt = 4'd0;
        co  = 1'b1;
      end else begin
        nxt = digit + 4'd1;
      end
    end else if (en) begin
      if (digit == 4'd0) begin
        nxt = DIGIT_MAX;
        co  = 1'b1;
      end else begin
        nxt = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-digit up/down BCD counter with prescaler, preset load,
// wrap flag and per-digit seven-segment outputs.
module bcd_display_counter
  import bcd_display_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int PRESC_W  = 26,
  parameter int LZ_BLANK = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  run,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int NB = 4 * DIGITS;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic               tick_cond;
  logic [NB-1:0]      bcd_next;
  logic               chain [DIGITS+1];

  assign tick_cond = run && (presc == PRESC_LAST);
  assign chain[0]  = tick_cond && !load;

  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    bcd_digit_cell u_cell (
      .digit    (bcd[4*i +: 4]),
      .up       (up),
      .en       (chain[i]),
      .load     (load),
      .load_nib (load_value[4*i +: 4]),
      .nxt      (bcd_next[4*i +: 4]),
      .co       (chain[i+1])
    );
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
    end else if (load || tick_cond) begin
      presc <= '0;
    end else if (run) begin
      presc <= presc + 1'b1;
    end
  end

  // Carry out of the top digit only fires when every digit rolled over.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      bcd  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      bcd  <= bcd_next;
      tick <= tick_cond && !load;
      wrap <= chain[DIGITS];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    logic [6:0] raw;

    bcd7seg u_seg (
      .bcd (bcd[4*i +: 4]),
      .seg (raw)
    );

    if (i > 0 && LZ_BLANK != 0) begin : g_lz
      assign hex[7*i +: 7] = (bcd[NB-1:4*i] == '0) ? SEG_BLANK : raw;
    end else begin : g_plain
      assign hex[7*i +: 7] = raw;
    end
  end

endmodule

// File: tb/tb_bcd_display_counter.sv
// Bench for bcd_display_counter: directed steps plus random traffic
// checked against an integer-valued reference model.
module tb_bcd_display_counter;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 4;
  localparam int PRESC_W  = 3;
  localparam int MOD      = 1000;

  logic        clk;
  logic        rst;
  logic        run;
  logic        up;
  logic        load;
  logic [11:0] load_value;
  logic [11:0] bcd;
  logic        tick;
  logic        wrap;
  logic [20:0] hex;

  int n_checks = 0;
  int n_fail   = 0;

  int m_count;
  int m_presc;
  bit m_tick;
  bit m_wrap;

  string lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  bcd_display_counter #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W),
    .LZ_BLANK (1)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .run        (run),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .bcd        (bcd),
    .tick       (tick),
    .wrap       (wrap),
    .hex        (hex)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] r;
    string s;
    r = 7'h7f;
    s = lit[d];
    for (int k = 0; k < s.len(); k++) r[s[k] - "a"] = 1'b0;
    return r;
  endfunction

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [20:0] exp_hex(input int v);
    logic [20:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && v / pow10(i) == 0) r[7*i +: 7] = 7'h7f;
      else r[7*i +: 7] = seg_of((v / pow10(i)) % 10);
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [11:0] lv);
    int v;
    int n;
    v = 0;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * pow10(i);
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bcd"}, 32'(bcd), 32'(to_bcd(m_count)));
    check({tag, ".tick"}, 32'(tick), 32'(m_tick));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, ".hex"}, 32'(hex), 32'(exp_hex(m_count)));
  endtask

  task automatic model_reset();
    m_count = 0;
    m_presc = 0;
    m_tick  = 0;
    m_wrap  = 0;
  endtask

  task automatic step(input string tag, input logic r, input logic u,
                      input logic l, input logic [11:0] lv);
    run = r;
    up = u;
    load = l;
    load_value = lv;
    @(posedge clk);
    m_tick = 0;
    m_wrap = 0;
    if (l) begin
      m_count = clamp_val(lv);
      m_presc = 0;
    end else if (r && m_presc == TICK_DIV - 1) begin
      m_presc = 0;
      m_tick = 1;
      if (u) begin
        m_wrap = (m_count == MOD - 1);
        m_count = (m_count + 1) % MOD;
      end else begin
        m_wrap = (m_count == 0);
        m_count = (m_count + MOD - 1) % MOD;
      end
    end else if (r) begin
      m_presc++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    up = 1'b1;
    load = 1'b0;
    load_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    for (int k = 0; k < 12; k++) step("count_up", 1, 1, 0, 12'h000);
    check("after12", 32'(bcd), 32'h003);

    step("load998", 1, 1, 1, 12'h998);
    for (int k = 0; k < 8; k++) step("wrap_up", 1, 1, 0, 12'h000);

    step("load000", 1, 0, 1, 12'h000);
    for (int k = 0; k < 8; k++) step("wrap_down", 1, 0, 0, 12'h000);

    step("loadAF3", 1, 1, 1, 12'hAF3);
    check("clamp", 32'(bcd), 32'h993);
    for (int k = 0; k < 4; k++) step("restart", 1, 1, 0, 12'h000);

    for (int k = 0; k < 8 && m_presc != TICK_DIV - 1; k++)
      step("align", 1, 1, 0, 12'h000);
    step("load_vs_tick", 1, 1, 1, 12'h050);
    check("load_wins", 32'(bcd), 32'h050);
    for (int k = 0; k < 10; k++) begin
      step("paused", 0, 1, 0, 12'h000);
      check("paused.tick", 32'(tick), 32'h0);
    end
    for (int k = 0; k < 4; k++) step("resume", 1, 1, 0, 12'h000);

    step("load007", 1, 1, 1, 12'h007);
    check("lz_d2", 32'(hex[20:14]), 32'h7f);
    check("lz_d1", 32'(hex[13:7]), 32'h7f);
    check("lz_d0", 32'(hex[6:0]), 32'(7'b1111000));

    for (int k = 0; k < 400; k++) begin
      step("random",
           logic'($urandom_range(3, 0) != 0),
           logic'($urandom_range(1, 0)),
           logic'($urandom_range(19, 0) == 0),
           12'($urandom));
    end

    step("load123", 1, 1, 1, 12'h123);
    step("mid1", 1, 1, 0, 12'h000);
    step("mid2", 1, 1, 0, 12'h000);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step("post_rst", 1, 1, 0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
